// File: rtl/mbssoc_int_dispatch.sv
// -----------------------------------------------------------------------------
// mbssoc_int_dispatch
//
// Interrupt dispatcher between the SoC device IRQ lines and the two MBScore
// cores. Rising irq edges are latched as pending requests. The lowest-index
// pending source that no core currently owns is handed to an idle, enabled
// core, with round-robin choice between the two cores. Each core then runs
// its own deliver / take / end-of-interrupt handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   irq[NUM_SRC]      device request levels; a 0->1 edge is a new request
//   dev_ack[NUM_SRC]  one-cycle pulse to the device whose request was taken
//   core_en[2]        per-core interrupt enable
//   core_int[2]       per-core request, high while in DELIVER
//   int_num_out0/1    source number owned by core0 / core1
//   core_take[2]      core accepts the delivered interrupt (pulse)
//   core_eoi[2]       core finished servicing (pulse)
//   pending[NUM_SRC]  latched requests not yet taken
//   dbg_state[4]      {core1 state, core0 state}: 0=IDLE 1=DELIVER 2=SERVICE
//
// Handshake: a delivery is offered by core_int[k]=1 with int_num_outk
// stable; it completes in the cycle core_take[k]=1 is seen, which is also
// the only cycle dev_ack[src] is high. A take seen in any other state is
// ignored, as is an eoi outside SERVICE.
// -----------------------------------------------------------------------------
module mbssoc_int_dispatch #(
  parameter int NUM_SRC      = 5,
  parameter int SEL_W        = 3,
  parameter int TAKE_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  output logic [NUM_SRC-1:0] dev_ack,
  input  logic [1:0]         core_en,
  output logic [1:0]         core_int,
  output logic [SEL_W-1:0]   int_num_out0,
  output logic [SEL_W-1:0]   int_num_out1,
  input  logic [1:0]         core_take,
  input  logic [1:0]         core_eoi,
  output logic [NUM_SRC-1:0] pending,
  output logic [3:0]         dbg_state
);

  localparam int CNT_W = (TAKE_TIMEOUT > 1) ? $clog2(TAKE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELIVER = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] r_irq_q;
  logic [NUM_SRC-1:0] r_pending;
  state_t             r_state [2];
  logic [SEL_W-1:0]   r_src   [2];
  logic [CNT_W-1:0]   r_cnt   [2];
  logic               r_rr;
  logic [1:0]         r_skip;

  state_t             w_state_nxt [2];
  logic [NUM_SRC-1:0] w_owned;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_found;
  logic [SEL_W-1:0]   w_cand;
  logic [1:0]         w_idle_en;
  logic               w_gnt_any;
  logic               w_gnt_core;
  logic [1:0]         w_withdraw;

  // Source ownership, eligibility and lowest-index pick.
  always_comb begin
    w_owned = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_state[k] != ST_IDLE && r_src[k] == SEL_W'(i)) w_owned[i] = 1'b1;
      end
    end
    w_elig  = r_pending & ~w_owned;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_cand  = SEL_W'(i);
      end
    end
  end

  // Core arbitration. A core that just timed out is passed over once when
  // the other core can take the delivery instead.
  always_comb begin
    w_idle_en[0] = (r_state[0] == ST_IDLE) && core_en[0];
    w_idle_en[1] = (r_state[1] == ST_IDLE) && core_en[1];
    w_gnt_any    = w_found && (|w_idle_en);
    w_gnt_core   = 1'b0;
    if (&w_idle_en) begin
      if (r_skip[0] && !r_skip[1])      w_gnt_core = 1'b1;
      else if (r_skip[1] && !r_skip[0]) w_gnt_core = 1'b0;
      else                              w_gnt_core = r_rr;
    end else begin
      w_gnt_core = w_idle_en[1];
    end
  end

  // Per-core next state and take/withdraw decode.
  always_comb begin
    dev_ack    = '0;
    w_withdraw = '0;
    for (int k = 0; k < 2; k++) begin
      w_state_nxt[k] = r_state[k];
      case (r_state[k])
        ST_IDLE: begin
          if (w_gnt_any && (w_gnt_core == k[0])) w_state_nxt[k] = ST_DELIVER;
        end
        ST_DELIVER: begin
          if (core_take[k]) begin
            w_state_nxt[k] = ST_SERVICE;
            for (int i = 0; i < NUM_SRC; i++) begin
              if (r_src[k] == SEL_W'(i)) dev_ack[i] = 1'b1;
            end
          end else if (!core_en[k] || r_cnt[k] == CNT_W'(TAKE_TIMEOUT - 1)) begin
            w_state_nxt[k] = ST_IDLE;
            w_withdraw[k]  = 1'b1;
          end
        end
        ST_SERVICE: begin
          if (core_eoi[k]) w_state_nxt[k] = ST_IDLE;
        end
        default: w_state_nxt[k] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading the live levels means lines already high at release raise
      // no request.
      r_irq_q   <= irq;
      r_pending <= '0;
      r_rr      <= 1'b0;
      r_skip    <= '0;
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= ST_IDLE;
        r_src[k]   <= '0;
        r_cnt[k]   <= '0;
      end
    end else begin
      r_irq_q <= irq;
      // A new edge in the take cycle must survive, so set beats clear.
      r_pending <= (r_pending & ~dev_ack) | (irq & ~r_irq_q);
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= w_state_nxt[k];
        if (r_state[k] == ST_IDLE && w_state_nxt[k] == ST_DELIVER) begin
          r_src[k] <= w_cand;
          r_cnt[k] <= '0;
        end else if (r_state[k] == ST_DELIVER) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
      if (w_gnt_any) begin
        r_rr   <= ~w_gnt_core;
        r_skip <= w_withdraw;
      end else begin
        r_skip <= r_skip | w_withdraw;
      end
    end
  end

  assign pending      = r_pending;
  assign core_int[0]  = (r_state[0] == ST_DELIVER);
  assign core_int[1]  = (r_state[1] == ST_DELIVER);
  assign int_num_out0 = r_src[0];
  assign int_num_out1 = r_src[1];
  assign dbg_state    = {r_state[1], r_state[0]};

endmodule

// File: tb/tb_mbssoc_int_dispatch.sv
// -----------------------------------------------------------------------------
// tb_mbssoc_int_dispatch
//
// Directed bench for mbssoc_int_dispatch. Inputs change 1 time unit after
// the rising edge and registered outputs are read at the same point, so a
// value read after tick() is the state produced by that edge. dev_ack is
// watched on the falling edge and matched against exp_q, the list of
// source numbers whose takes were issued, in order.
// -----------------------------------------------------------------------------
module tb_mbssoc_int_dispatch;

  localparam int NUM_SRC = 5;
  localparam int SEL_W   = 3;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq;
  logic [NUM_SRC-1:0] dev_ack;
  logic [1:0]         core_en;
  logic [1:0]         core_int;
  logic [SEL_W-1:0]   int_num_out0;
  logic [SEL_W-1:0]   int_num_out1;
  logic [1:0]         core_take;
  logic [1:0]         core_eoi;
  logic [NUM_SRC-1:0] pending;
  logic [3:0]         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [SEL_W-1:0] exp_q[$];

  mbssoc_int_dispatch #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .TAKE_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .dev_ack(dev_ack), .core_en(core_en),
    .core_int(core_int), .int_num_out0(int_num_out0), .int_num_out1(int_num_out1),
    .core_take(core_take), .core_eoi(core_eoi), .pending(pending),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic take(input int k, input logic [SEL_W-1:0] src);
    exp_q.push_back(src);
    core_take[k] = 1'b1;
    tick();
    core_take = 2'b00;
  endtask

  task automatic eoi(input int k);
    core_eoi[k] = 1'b1;
    tick();
    core_eoi = 2'b00;
  endtask

  // Scoreboard: every dev_ack pulse must match the next expected take.
  always @(negedge clk) begin
    if (dev_ack !== '0) begin
      if (exp_q.size() == 0) begin
        chk("dev_ack_unexpected", 32'(dev_ack), 32'd0);
      end else begin
        logic [31:0] oh;
        oh = 32'd1 << exp_q.pop_front();
        chk("dev_ack", 32'(dev_ack), oh);
      end
    end
  end

  initial begin
    rst = 1'b1; irq = '0; core_en = 2'b00; core_take = 2'b00; core_eoi = 2'b00;
    repeat (3) tick();
    chk("rst_pending",  32'(pending),   32'd0);
    chk("rst_core_int", 32'(core_int),  32'd0);
    chk("rst_num0",     32'(int_num_out0), 32'd0);
    chk("rst_num1",     32'(int_num_out1), 32'd0);
    chk("rst_state",    32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Single source on UART
    core_en = 2'b11;
    repeat (2) tick();
    irq = 5'b00100;
    tick();
    chk("s1_pending",   32'(pending),  32'h04);
    chk("s1_int_early", 32'(core_int), 32'd0);
    tick();
    chk("s1_core_int",  32'(core_int), 32'd1);
    chk("s1_num0",      32'(int_num_out0), 32'd2);
    tick();
    take(0, 3'd2);
    chk("s1_pend_clr",  32'(pending),  32'd0);
    chk("s1_int_drop",  32'(core_int), 32'd0);
    chk("s1_service",   32'(dbg_state), 32'h2);
    chk("s1_num_hold",  32'(int_num_out0), 32'd2);
    irq = '0;
    repeat (3) tick();
    eoi(0);
    chk("s1_idle",      32'(dbg_state), 32'h0);
    chk("s1_no_redel",  32'(core_int), 32'd0);

    // Priority and round-robin
    do_reset();
    irq = 5'b10010;
    tick();
    chk("s2_pending",   32'(pending),  32'h12);
    tick();
    chk("s2_int0",      32'(core_int), 32'd1);
    chk("s2_num0",      32'(int_num_out0), 32'd1);
    tick();
    chk("s2_int_both",  32'(core_int), 32'd3);
    chk("s2_num1",      32'(int_num_out1), 32'd4);
    take(0, 3'd1);
    chk("s2_pend_a",    32'(pending),  32'h10);
    take(1, 3'd4);
    chk("s2_pend_b",    32'(pending),  32'h00);
    chk("s2_service",   32'(dbg_state), 32'hA);
    eoi(0);
    eoi(1);
    irq = '0;
    chk("s2_idle",      32'(dbg_state), 32'h0);

    // Take timeout with only core0 enabled
    do_reset();
    core_en = 2'b01;
    irq = 5'b00001;
    tick();
    tick();
    chk("s3_deliver",   32'(core_int), 32'd1);
    repeat (15) tick();
    chk("s3_still",     32'(core_int), 32'd1);
    tick();
    chk("s3_withdrawn", 32'(core_int), 32'd0);
    chk("s3_pending",   32'(pending),  32'h01);
    tick();
    chk("s3_redeliver", 32'(core_int), 32'd1);
    chk("s3_num0",      32'(int_num_out0), 32'd0);
    take(0, 3'd0);
    eoi(0);
    irq = '0;

    // Disable core1 mid-delivery
    do_reset();
    core_en = 2'b10;
    irq = 5'b01000;
    tick();
    tick();
    chk("s4_int1",      32'(core_int), 32'h2);
    chk("s4_num1",      32'(int_num_out1), 32'd3);
    core_en = 2'b01;
    tick();
    chk("s4_drop1",     32'(core_int), 32'd0);
    chk("s4_pending",   32'(pending),  32'h08);
    tick();
    chk("s4_int0",      32'(core_int), 32'h1);
    chk("s4_num0",      32'(int_num_out0), 32'd3);
    take(0, 3'd3);
    eoi(0);
    irq = '0;

    // Edge merge and set/clear collision
    do_reset();
    core_en = 2'b01;
    irq = 5'b01000;
    tick();
    irq = '0;
    tick();
    chk("s5_deliver",   32'(core_int), 32'd1);
    irq = 5'b01000;
    tick();
    chk("s5_merge",     32'(pending),  32'h08);
    irq = '0;
    tick();
    irq = 5'b01000;
    take(0, 3'd3);
    chk("s5_set_wins",  32'(pending),  32'h08);
    chk("s5_service",   32'(dbg_state), 32'h2);
    tick();
    chk("s5_owned",     32'(core_int), 32'd0);
    eoi(0);
    tick();
    chk("s5_redeliver", 32'(core_int), 32'd1);
    take(0, 3'd3);
    chk("s5_pend_clr",  32'(pending),  32'd0);

    // Reset while core0 is in SERVICE; irq[3] is still high
    chk("s6_pre_state", 32'(dbg_state), 32'h2);
    do_reset();
    chk("s6_state",     32'(dbg_state), 32'h0);
    chk("s6_core_int",  32'(core_int),  32'd0);
    chk("s6_num0",      32'(int_num_out0), 32'd0);
    chk("s6_pending",   32'(pending),   32'd0);
    eoi(0);
    chk("s6_stale_eoi", 32'(dbg_state), 32'h0);
    repeat (2) tick();
    chk("s6_no_req",    32'(pending),   32'd0);
    chk("s6_no_int",    32'(core_int),  32'd0);
    irq = '0;
    tick();

    chk("ack_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mbssoc_int_dispatch.md
Name: mbssoc_int_dispatch

Overview:
- Interrupt dispatcher between the SoC peripheral interrupt lines (keyboard, mouse, UART, storage, Ethernet) and the two MBScore cores.
- Latches device requests as pending and picks the highest-priority one.
- Assigns it to an available core by round-robin, then runs a per-core deliver / take / end-of-interrupt handshake.
- Sits between the device IRQ wires and the core `int` / `int_num` inputs and replaces ad-hoc level routing with a sequenced, acknowledged scheme.

Parameters:
- NUM_SRC, 5, number of device interrupt sources; index 0 is highest priority (0=keyboard, 1=mouse, 2=UART, 3=storage, 4=Ethernet).
- SEL_W, 3, width of the interrupt number presented to a core; must satisfy 2^SEL_W > NUM_SRC.
- TAKE_TIMEOUT, 16, cycles a core may leave a delivered interrupt untaken before it is withdrawn.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq  input  NUM_SRC  device request lines, level; a 0->1 transition marks a new request.
- dev_ack  output  NUM_SRC  one-cycle pulse to the device when its request is taken by a core.
- core_en  input  2  per-core interrupt enable (bit0 = core0, bit1 = core1).
- core_int  output  2  per-core interrupt request, held until taken or withdrawn.
- int_num_out0  output  SEL_W  source number delivered to core0; valid while core_int[0]=1.
- int_num_out1  output  SEL_W  source number delivered to core1; valid while core_int[1]=1.
- core_take  input  2  core accepts the delivered interrupt; single-cycle pulse.
- core_eoi  input  2  core signals end of service; single-cycle pulse.
- pending  output  NUM_SRC  status: latched, not yet taken requests.

Behaviour:
- Reset values:
  - pending=0, dev_ack=0, core_int=0, int_num_out0/1=0.
  - Both cores in IDLE; round-robin pointer = core0; timeout counters = 0.
  - irq edge-detect register loads the current irq value, so levels already high at reset release raise no request.
- Pending latch:
  - Bit i is set on the cycle after irq[i] rises.
  - Bit i is cleared on the cycle its dispatched interrupt is taken.
  - A set and a clear in the same cycle: set wins, so the new edge is not lost.
  - A further rising edge while bit i is pending or in service merges; no counting.
- Source selection: the lowest-index pending bit not currently delivered or in service on either core. Each source is owned by at most one core at a time.
- Per-core FSM (core k):
  - IDLE: go to DELIVER when core_en[k]=1, an eligible source exists, and arbitration grants core k. On entry, core_int[k]=1, int_num_outk=source, timeout counter cleared.
  - DELIVER, take: if core_take[k]=1, then dev_ack[src] pulses for exactly that cycle, pending[src] clears, core_int[k] drops, and the FSM goes to SERVICE.
  - DELIVER, timeout: if the counter reaches TAKE_TIMEOUT-1 with no take, or core_en[k] falls, then core_int[k] drops, the source stays pending and becomes eligible again, and the FSM goes to IDLE. The counter increments every cycle in DELIVER.
  - SERVICE: core_int[k]=0 and int_num_outk holds the source number. core_eoi[k]=1 returns the FSM to IDLE, and the source becomes eligible the next cycle.
  - core_take outside DELIVER and core_eoi outside SERVICE are ignored.
- Arbitration:
  - At most one new delivery starts per cycle.
  - If both cores are IDLE and enabled, the round-robin pointer picks the core and then toggles.
  - If only one is eligible, it is granted and the pointer moves to the other core.
  - Delivery latency: irq rise at edge n, pending at n+1, core_int at n+2 if a core is IDLE.
- Timeout withdrawal: the next grant skips the core that timed out, for one arbitration only, if the other core is eligible.
- Reset asserted mid-handshake: everything returns to reset values on the next edge and in-flight interrupts are dropped; devices must re-raise irq.

Test Plan:
- Single source: irq[2] rises at cycle 10, core_en=2'b11 → pending[2]=1 at 11; core_int[0]=1 and int_num_out0=2 at 12; core_take[0] at 14 → dev_ack[2] pulse at 14, pending[2]=0 from 15; core_eoi[0] at 20 → core0 IDLE at 21.
- Priority and round-robin: irq[4] and irq[1] rise in the same cycle → core0 gets 1 first; the next cycle core1 gets 4; int_num_out1=4; both dev_acks pulse on their respective takes.
- Timeout: core_en=2'b01, irq[0] rises, no take for 16 cycles → core_int[0] drops after the 16th DELIVER cycle, pending[0] stays 1, redelivery follows on the next cycle.
- Disable mid-delivery: core1 in DELIVER, core_en[1] falls → core_int[1]=0 the next cycle; the source is redelivered to core0 if core0 is enabled and IDLE.
- Edge merge / set-clear collision: irq[3] pulses twice before take → exactly one dev_ack; an edge coinciding with the take cycle leaves pending[3]=1 afterwards.
- Reset mid-SERVICE: rst high one cycle while core0 is in SERVICE → all outputs 0 and pending=0 the next cycle; a stale core_eoi[0] afterwards has no effect.
